// File: rtl/button_event.sv
// ---------------------------------------------------------------------------
// button_event
//   Turns a debounced, clk-domain button level into discrete UI events:
//   press, release, long-press (hold), and optional auto-repeat while held.
//
// Optional feature macro:
//   BUTTON_EVENT_AUTO_REPEAT_EN  - when defined, repeat_pulse fires every
//                                  REPEAT_CYCLES cycles while long-pressed;
//                                  when undefined, repeat_pulse is always 0.
//
// Parameters:
//   HOLD_CYCLES    press_pulse -> hold_pulse delay in clk cycles (2..2^26-1)
//   REPEAT_CYCLES  auto-repeat period in clk cycles (2..2^26-1)
//
// Ports:
//   clk            system clock, rising edge
//   rst            synchronous active-high reset
//   btn_level      debounced button level (1 = pressed)
//   press_pulse    1-cycle strobe on a new press
//   release_pulse  1-cycle strobe when a counted press is released
//   hold_pulse     1-cycle strobe when a press becomes a long-press
//   repeat_pulse   1-cycle auto-repeat strobe while long-pressed
//   held           level, high while in long-press
//   press_count    8-bit wrapping count of press_pulse events
// ---------------------------------------------------------------------------
module button_event #(
  parameter int HOLD_CYCLES   = 50_000_000,
  parameter int REPEAT_CYCLES = 10_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_level,
  output logic       press_pulse,
  output logic       release_pulse,
  output logic       hold_pulse,
  output logic       repeat_pulse,
  output logic       held,
  output logic [7:0] press_count
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESSED = 2'd1,
    HELD    = 2'd2
  } state_t;

  // The timer counts 0..N-1; the event fires on the edge where it sits at
  // N-1, so the pulse lands exactly N cycles after the previous pulse.
  localparam logic [25:0] HOLD_LAST   = 26'(HOLD_CYCLES - 1);
  localparam logic [25:0] REPEAT_LAST = 26'(REPEAT_CYCLES - 1);

  state_t      state;
  logic [25:0] timer;
  logic        btn_q;
  logic        rise;
  logic        fall;

  assign rise = btn_level & ~btn_q;
  assign fall = ~btn_level & btn_q;

  // Button history, event FSM, timer and all registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      // btn_q resets to 1 so a button held through reset is not seen as
      // a fresh press; the aborted press also yields no release.
      state         <= IDLE;
      timer         <= 26'd0;
      btn_q         <= 1'b1;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      hold_pulse    <= 1'b0;
      repeat_pulse  <= 1'b0;
      held          <= 1'b0;
      press_count   <= 8'd0;
    end else begin
      btn_q         <= btn_level;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      hold_pulse    <= 1'b0;
      repeat_pulse  <= 1'b0;

      case (state)
        IDLE: begin
          // A falling edge here is ignored: nothing was counted.
          if (rise) begin
            state       <= PRESSED;
            timer       <= 26'd0;
            press_pulse <= 1'b1;
            press_count <= press_count + 8'd1;
          end
        end

        PRESSED: begin
          // Release is checked first so it wins a tie with the threshold.
          if (fall) begin
            state         <= IDLE;
            timer         <= 26'd0;
            release_pulse <= 1'b1;
            held          <= 1'b0;
          end else if (timer == HOLD_LAST) begin
            state      <= HELD;
            timer      <= 26'd0;
            hold_pulse <= 1'b1;
            held       <= 1'b1;
          end else begin
            timer <= timer + 26'd1;
          end
        end

        HELD: begin
          if (fall) begin
            state         <= IDLE;
            timer         <= 26'd0;
            release_pulse <= 1'b1;
            held          <= 1'b0;
          end else if (timer == REPEAT_LAST) begin
            // Without auto-repeat the timer still wraps here, but nothing
            // observable depends on it; HELD just waits for release.
            timer <= 26'd0;
`ifdef BUTTON_EVENT_AUTO_REPEAT_EN
            repeat_pulse <= 1'b1;
`else
            repeat_pulse <= 1'b0;
`endif
          end else begin
            timer <= timer + 26'd1;
          end
        end

        default: begin
          state <= IDLE;
          timer <= 26'd0;
          held  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_button_event.sv
// ---------------------------------------------------------------------------
// tb_button_event
//   Directed self-checking bench for button_event with HOLD_CYCLES=8 and
//   REPEAT_CYCLES=4. Inputs are driven 1 time unit after a rising edge;
//   outputs are sampled 1 time unit after the next rising edge, so the
//   outputs seen after the k-th tick reflect inputs of cycle k-1.
//   Works with or without BUTTON_EVENT_AUTO_REPEAT_EN defined.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_button_event;

  logic       clk;
  logic       rst;
  logic       btn_level;
  logic       press_pulse;
  logic       release_pulse;
  logic       hold_pulse;
  logic       repeat_pulse;
  logic       held;
  logic [7:0] press_count;

  int checks;
  int errors;
  int n_press;
  int n_release;

  button_event #(
    .HOLD_CYCLES  (8),
    .REPEAT_CYCLES(4)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .btn_level    (btn_level),
    .press_pulse  (press_pulse),
    .release_pulse(release_pulse),
    .hold_pulse   (hold_pulse),
    .repeat_pulse (repeat_pulse),
    .held         (held),
    .press_count  (press_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Checks all five one-bit outputs in the current cycle.
  task automatic chk_out(input string tag, input logic p, input logic r,
                         input logic h, input logic rp, input logic hd);
    chk({tag, ".press"},   8'(press_pulse),   8'(p));
    chk({tag, ".release"}, 8'(release_pulse), 8'(r));
    chk({tag, ".hold"},    8'(hold_pulse),    8'(h));
    chk({tag, ".repeat"},  8'(repeat_pulse),  8'(rp));
    chk({tag, ".held"},    8'(held),          8'(hd));
  endtask

  function automatic logic exp_repeat(input int n);
`ifdef BUTTON_EVENT_AUTO_REPEAT_EN
    return (n == 13) || (n == 17) || (n == 21) || (n == 25) || (n == 29);
`else
    return (n < 0);
`endif
  endfunction

  initial begin
    int n;
    checks    = 0;
    errors    = 0;
    rst       = 1'b1;
    btn_level = 1'b0;

    // Reset state
    tick();
    tick();
    chk_out("reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("reset.count", press_count, 8'd0);

    // Leaving reset with btn=0: falling edge in IDLE gives no pulse
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk_out("idle_fall", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    end

    // Short press: rise at cycle 0, fall at cycle 4
    for (int c = 0; c < 8; c++) begin
      btn_level = (c < 4);
      tick();
      n = c + 1;
      chk_out("short", 1'(n == 1), 1'(n == 5), 1'b0, 1'b0, 1'b0);
    end
    chk("short.count", press_count, 8'd1);

    // Long press: high cycles 0..29
    for (int c = 0; c < 34; c++) begin
      btn_level = (c < 30);
      tick();
      n = c + 1;
      chk_out("long", 1'(n == 1), 1'(n == 31), 1'(n == 9), exp_repeat(n),
              1'(n >= 9 && n <= 30));
    end
    chk("long.count", press_count, 8'd2);

    // Race: release sampled on the hold-threshold edge
    for (int c = 0; c < 12; c++) begin
      btn_level = (c < 8);
      tick();
      n = c + 1;
      chk_out("race", 1'(n == 1), 1'(n == 9), 1'b0, 1'b0, 1'b0);
    end
    chk("race.count", press_count, 8'd3);

    // Reset mid-HELD with button kept high
    for (int c = 0; c < 12; c++) begin
      btn_level = 1'b1;
      tick();
    end
    chk("prereset.held", 8'(held), 8'd1);
    rst = 1'b1;
    tick();
    tick();
    chk_out("rst_held", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("rst_held.count", press_count, 8'd0);
    rst = 1'b0;
    for (int c = 0; c < 12; c++) begin
      btn_level = (c < 8);     // stays high, then released: no pulses at all
      tick();
      chk_out("post_rst", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    end
    chk("post_rst.count", press_count, 8'd0);
    btn_level = 1'b1;
    tick();
    chk_out("post_rst_press", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("post_rst_press.count", press_count, 8'd1);
    btn_level = 1'b0;
    tick();
    chk_out("post_rst_rel", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);

    // Wrap: reset, then 256 one-cycle presses
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    n_press   = 0;
    n_release = 0;
    for (int i = 0; i < 256; i++) begin
      btn_level = 1'b1;
      tick();
      n_press   += int'(press_pulse);
      n_release += int'(release_pulse);
      if (i == 254) chk("wrap.count255", press_count, 8'd255);
      btn_level = 1'b0;
      tick();
      n_press   += int'(press_pulse);
      n_release += int'(release_pulse);
    end
    chk("wrap.count0", press_count, 8'd0);
    chk("wrap.n_press_lo", 8'(n_press), 8'(256));
    chk("wrap.n_press_hi", 8'(n_press >> 8), 8'd1);
    chk("wrap.n_release_lo", 8'(n_release), 8'(256));
    chk("wrap.n_release_hi", 8'(n_release >> 8), 8'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
